// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage
// Description : Reusable pipeline stage register with valid/ready handshake,
//               flush-to-bubble, an optional two-entry skid buffer and a
//               saturating stall counter.
//
//   Parameters
//     DATA_W  payload width in bits
//     RST_VAL bubble/NOP payload loaded on reset and on flush
//     SKID    1: two-entry skid buffer, registered in_ready_o
//             0: single register, combinational in_ready_o
//     CNT_W   stall counter width
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     flush_i      synchronous kill: empty the stage, load the bubble
//     in_valid_i   upstream payload valid
//     in_ready_o   stage can accept
//     in_data_i    upstream payload
//     out_valid_o  payload valid to downstream
//     out_ready_i  downstream accepts
//     out_data_o   payload to downstream
//     cnt_clr_i    synchronous clear of the stall counter
//     stall_cnt_o  cycles stalled by downstream, saturating
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter bit                SKID    = 1'b1,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [DATA_W-1:0] r_main;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_in_xfer  = in_valid_i & w_in_ready;
    assign w_out_xfer = w_out_valid & out_ready_i;

    generate
        if (SKID) begin : g_skid
            localparam logic [1:0] c_st_empty     = 2'd0;
            localparam logic [1:0] c_st_full      = 2'd1;
            localparam logic [1:0] c_st_skid_full = 2'd2;

            logic [1:0]        r_state;
            logic [1:0]        w_state_nxt;
            logic              r_in_ready;
            logic [DATA_W-1:0] r_skid;
            logic              w_load_main_in;
            logic              w_load_main_skid;
            logic              w_load_skid;

            always_comb begin
                w_state_nxt      = r_state;
                w_load_main_in   = 1'b0;
                w_load_main_skid = 1'b0;
                w_load_skid      = 1'b0;
                case (r_state)
                    c_st_empty: begin
                        if (w_in_xfer) begin
                            w_load_main_in = 1'b1;
                            w_state_nxt    = c_st_full;
                        end
                    end
                    c_st_full: begin
                        if (w_out_xfer && w_in_xfer) begin
                            w_load_main_in = 1'b1;
                        end else if (w_out_xfer) begin
                            w_state_nxt = c_st_empty;
                        end else if (w_in_xfer) begin
                            // Downstream stalled while one payload was in
                            // flight: park it behind main.
                            w_load_skid = 1'b1;
                            w_state_nxt = c_st_skid_full;
                        end
                    end
                    c_st_skid_full: begin
                        if (w_out_xfer) begin
                            w_load_main_skid = 1'b1;
                            w_state_nxt      = c_st_full;
                        end
                    end
                    default: w_state_nxt = c_st_empty;
                endcase
                if (flush_i) begin
                    w_state_nxt      = c_st_empty;
                    w_load_main_in   = 1'b0;
                    w_load_main_skid = 1'b0;
                    w_load_skid      = 1'b0;
                end
            end

            // in_ready is derived from the next state so it is a pure flop
            // output with no path from out_ready_i.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state    <= c_st_empty;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != c_st_skid_full);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_main <= RST_VAL;
                    r_skid <= RST_VAL;
                end else begin
                    if (flush_i) begin
                        r_main <= RST_VAL;
                    end else if (w_load_main_in) begin
                        r_main <= in_data_i;
                    end else if (w_load_main_skid) begin
                        r_main <= r_skid;
                    end
                    if (w_load_skid) begin
                        r_skid <= in_data_i;
                    end
                end
            end

            assign w_out_valid = (r_state != c_st_empty);
            assign w_in_ready  = r_in_ready;
        end else begin : g_no_skid
            logic r_valid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= 1'b0;
                    r_main  <= RST_VAL;
                end else if (flush_i) begin
                    r_valid <= 1'b0;
                    r_main  <= RST_VAL;
                end else if (w_in_xfer) begin
                    r_valid <= 1'b1;
                    r_main  <= in_data_i;
                end else if (w_out_xfer) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_out_valid = r_valid;
            assign w_in_ready  = ~r_valid | out_ready_i;
        end
    endgenerate

    // Clear wins over increment; flush leaves the count alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready_i && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign out_data_o  = r_main;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipe_stage
// Description : Scoreboard bench for pipe_stage. Two instances (skid buffer
//               and combinational-ready variants) share one stimulus stream;
//               each is checked against a FIFO-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage;

    localparam int              DW = 32;
    localparam logic [DW-1:0]   RV = 32'h0000_0013;
    localparam int              A_MAX = 3;   // CNT_W = 2
    localparam int              B_MAX = 15;  // CNT_W = 4

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [1:0]    a_cnt;
    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [3:0]    b_cnt;

    pipe_stage #(.DATA_W(DW), .RST_VAL(RV), .SKID(1'b1), .CNT_W(2)) u_skid (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
        .cnt_clr_i(cnt_clr), .stall_cnt_o(a_cnt)
    );

    pipe_stage #(.DATA_W(DW), .RST_VAL(RV), .SKID(1'b0), .CNT_W(4)) u_comb (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
        .cnt_clr_i(cnt_clr), .stall_cnt_o(b_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each stage is a FIFO of accepted payloads, capacity 2
    // with skid, capacity 1 without. The "last" value is what the output
    // register still shows once the FIFO has drained.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] la = RV;
    logic [DW-1:0] lb = RV;
    int            ca = 0;
    int            cb = 0;
    bit            pa = 1'b0;   // monitor popped ahead of the coming edge
    bit            pb = 1'b0;

    task automatic model_reset();
        qa.delete(); qb.delete();
        la = RV; lb = RV;
        ca = 0; cb = 0;
        pa = 1'b0; pb = 1'b0;
    endtask

    // Stimulus side of the scoreboard: runs at the clock edge, pushes accepted
    // payloads and updates the expected stall counts.
    task automatic model_edge();
        int sa;
        int sb;
        sa = qa.size() + (pa ? 1 : 0);
        sb = qb.size() + (pb ? 1 : 0);
        if (cnt_clr) ca = 0;
        else if (sa > 0 && !out_ready && ca < A_MAX) ca++;
        if (cnt_clr) cb = 0;
        else if (sb > 0 && !out_ready && cb < B_MAX) cb++;
        if (flush) begin
            qa.delete(); la = RV;
            qb.delete(); lb = RV;
        end else begin
            if (in_valid && sa < 2) qa.push_back(in_data);
            if (in_valid && (sb == 0 || out_ready)) qb.push_back(in_data);
        end
        pa = 1'b0;
        pb = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit ordy,
                         input bit fl, input bit clr);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: compares on the falling edge, and pops the expected payload
    // whenever the DUT is presenting an output that downstream accepts.
    always @(negedge clk) begin
        chk("skid_valid", a_out_valid, qa.size() > 0);
        chk("skid_ready", a_in_ready, qa.size() < 2);
        chk("skid_data",  a_out_data, (qa.size() > 0) ? qa[0] : la);
        chk("skid_cnt",   a_cnt, ca);
        chk("comb_valid", b_out_valid, qb.size() > 0);
        chk("comb_ready", b_in_ready, (qb.size() == 0) || out_ready);
        chk("comb_data",  b_out_data, (qb.size() > 0) ? qb[0] : lb);
        chk("comb_cnt",   b_cnt, cb);
        if (rst && out_ready && qa.size() > 0) begin
            la = qa.pop_front();
            pa = 1'b1;
        end
        if (rst && out_ready && qb.size() > 0) begin
            lb = qb.pop_front();
            pb = 1'b1;
        end
    end

    initial begin
        // Reset
        @(posedge clk);
        #1;
        chk("rst_skid_valid", a_out_valid, 1'b0);
        chk("rst_skid_data",  a_out_data, RV);
        chk("rst_skid_ready", a_in_ready, 1'b1);
        chk("rst_comb_ready", b_in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: A in main, B into skid, C held upstream
        drive(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Flush while the skid is occupied; 0xD must vanish
        drive(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hD, 1'b0, 1'b1, 1'b0);
        chk("flush_data", a_out_data, RV);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stall counter saturation and clear
        drive(1'b1, 32'h5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("sat_cnt", a_cnt, 2'd3);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3);
        end

        // Asynchronous reset between edges, with data in flight
        for (int i = 0; i < 4; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_skid_valid", a_out_valid, 1'b0);
        chk("arst_skid_data",  a_out_data, RV);
        chk("arst_skid_cnt",   a_cnt, 2'd0);
        chk("arst_comb_valid", b_out_valid, 1'b0);
        chk("arst_comb_data",  b_out_data, RV);
        chk("arst_comb_cnt",   b_cnt, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0,
                  1'b0, 1'b0);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
